// File: rtl/ft245_channel_mux.sv
// ----------------------------------------------------------------------------
// ft245_channel_mux
//
// Shares one FT245 FIFO bridge between two on-chip packet channels.
//
// TX path: two packet sources compete for the bridge write port. The winner's
// packet goes out as a one-byte header followed by its payload. The header is
// {channel, length-1}.
//
// RX path: each byte popped from the bridge in header phase is decoded as a
// header. The payload bytes that follow are steered to the addressed
// receive channel.
//
// The TX and RX state machines run independently of each other.
//
// Ports
//   clk_50mhz            system clock, rising edge
//   rst_n                asynchronous active-low reset
//   wr_en/wr_data        bridge write strobe and byte
//   wr_full              bridge TX buffer full
//   rd_en                bridge pop strobe
//   rd_data              bridge RX head byte (first-word-fall-through)
//   rd_empty             bridge RX buffer empty
//   txN_req/len          packet request and payload length-1, N = 0,1
//   txN_data/valid/ready payload byte handshake
//   txN_done             pulse with acceptance of the last payload byte
//   rxN_data/valid/ready received payload handshake
//   rxN_last             current byte ends its packet
//   tx_busy / rx_busy    TX not idle / RX inside a payload
//
// Parameter
//   FIXED_PRIORITY       0 = round-robin, 1 = channel 0 wins ties
// ----------------------------------------------------------------------------

// Run-time safety properties for the bridge handshakes and channel exclusivity.
module ft245_channel_mux_checker (
    input logic clk_50mhz,
    input logic rst_n,
    input logic wr_en,
    input logic wr_full,
    input logic rd_en,
    input logic rd_empty,
    input logic tx0_done,
    input logic tx1_done,
    input logic rx0_valid,
    input logic rx1_valid
);

    // Never write into a full bridge buffer.
    a_no_write_when_full : assert property (@(posedge clk_50mhz) disable iff (!rst_n)
        wr_en |-> !wr_full);

    // Never pop an empty bridge buffer.
    a_no_pop_when_empty : assert property (@(posedge clk_50mhz) disable iff (!rst_n)
        rd_en |-> !rd_empty);

    // Only the granted channel can finish a packet.
    a_done_exclusive : assert property (@(posedge clk_50mhz) disable iff (!rst_n)
        !(tx0_done && tx1_done));

    // A done pulse always rides on a byte that is handed to the bridge.
    a_done_with_write : assert property (@(posedge clk_50mhz) disable iff (!rst_n)
        (tx0_done || tx1_done) |-> wr_en);

    // Only the addressed receive channel sees valid data.
    a_rx_valid_exclusive : assert property (@(posedge clk_50mhz) disable iff (!rst_n)
        !(rx0_valid && rx1_valid));

endmodule

module ft245_channel_mux #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    // bridge write port
    output logic       wr_en,
    output logic [7:0] wr_data,
    input  logic       wr_full,
    // bridge read port
    output logic       rd_en,
    input  logic [7:0] rd_data,
    input  logic       rd_empty,
    // transmit channel 0
    input  logic       tx0_req,
    input  logic [6:0] tx0_len,
    input  logic [7:0] tx0_data,
    input  logic       tx0_valid,
    output logic       tx0_ready,
    output logic       tx0_done,
    // transmit channel 1
    input  logic       tx1_req,
    input  logic [6:0] tx1_len,
    input  logic [7:0] tx1_data,
    input  logic       tx1_valid,
    output logic       tx1_ready,
    output logic       tx1_done,
    // receive channel 0
    output logic [7:0] rx0_data,
    output logic       rx0_valid,
    input  logic       rx0_ready,
    output logic       rx0_last,
    // receive channel 1
    output logic [7:0] rx1_data,
    output logic       rx1_valid,
    input  logic       rx1_ready,
    output logic       rx1_last,
    // status
    output logic       tx_busy,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_HDR  = 2'd1,
        T_PAY  = 2'd2
    } tx_state_t;

    typedef enum logic {
        R_HDR = 1'b0,
        R_PAY = 1'b1
    } rx_state_t;

    // ------------------------------------------------------------------
    // TX state
    // ------------------------------------------------------------------
    tx_state_t  tx_state_r;
    tx_state_t  tx_state_nxt_s;
    logic       grant_r;
    logic       grant_nxt_s;
    logic       last_grant_r;
    logic       last_grant_nxt_s;
    logic [6:0] cnt_r;
    logic [6:0] cnt_nxt_s;

    logic       arb_grant_s;
    logic       sel_valid_s;
    logic [7:0] sel_data_s;
    logic       hdr_accept_s;
    logic       pay_accept_s;
    logic       pay_last_accept_s;

    // ------------------------------------------------------------------
    // RX state
    // ------------------------------------------------------------------
    rx_state_t  rx_state_r;
    rx_state_t  rx_state_nxt_s;
    logic       ch_r;
    logic       ch_nxt_s;
    logic [6:0] rcnt_r;
    logic [6:0] rcnt_nxt_s;
    logic       sel_rx_ready_s;
    logic       rcnt_zero_s;

    // Granted source's payload signals, used only in T_PAY.
    assign sel_valid_s       = grant_r ? tx1_valid : tx0_valid;
    assign sel_data_s        = grant_r ? tx1_data  : tx0_data;
    assign hdr_accept_s      = (tx_state_r == T_HDR) && !wr_full;
    assign pay_accept_s      = (tx_state_r == T_PAY) && sel_valid_s && !wr_full;
    assign pay_last_accept_s = pay_accept_s && (cnt_r == 7'd0);
    assign tx_busy           = (tx_state_r != T_IDLE);

    // Arbitration: the tie-break uses the pointer of the previous grant.
    always_comb begin
        arb_grant_s = 1'b0;
        if (tx0_req && tx1_req) begin
            if (FIXED_PRIORITY != 0) begin
                arb_grant_s = 1'b0;
            end else begin
                arb_grant_s = ~last_grant_r;
            end
        end else if (tx1_req) begin
            arb_grant_s = 1'b1;
        end else begin
            arb_grant_s = 1'b0;
        end
    end

    // TX next-state logic: grant, header, then payload countdown.
    always_comb begin
        tx_state_nxt_s   = tx_state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        cnt_nxt_s        = cnt_r;
        case (tx_state_r)
            T_IDLE: begin
                if (tx0_req || tx1_req) begin
                    grant_nxt_s      = arb_grant_s;
                    last_grant_nxt_s = arb_grant_s;
                    cnt_nxt_s        = arb_grant_s ? tx1_len : tx0_len;
                    tx_state_nxt_s   = T_HDR;
                end else begin
                    tx_state_nxt_s   = T_IDLE;
                end
            end
            T_HDR: begin
                if (hdr_accept_s) begin
                    tx_state_nxt_s = T_PAY;
                end else begin
                    tx_state_nxt_s = T_HDR;
                end
            end
            T_PAY: begin
                if (pay_accept_s) begin
                    if (cnt_r == 7'd0) begin
                        tx_state_nxt_s = T_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r - 7'd1;
                    end
                end else begin
                    tx_state_nxt_s = T_PAY;
                end
            end
            default: begin
                tx_state_nxt_s = T_IDLE;
            end
        endcase
    end

    // Bridge write port and source handshakes, decoded from TX state.
    always_comb begin
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        tx0_ready = 1'b0;
        tx1_ready = 1'b0;
        tx0_done  = 1'b0;
        tx1_done  = 1'b0;
        case (tx_state_r)
            T_HDR: begin
                wr_en   = ~wr_full;
                wr_data = {grant_r, cnt_r};
            end
            T_PAY: begin
                wr_en   = sel_valid_s & ~wr_full;
                wr_data = sel_data_s;
                if (grant_r) begin
                    tx1_ready = ~wr_full;
                    tx1_done  = pay_last_accept_s;
                end else begin
                    tx0_ready = ~wr_full;
                    tx0_done  = pay_last_accept_s;
                end
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // TX registers; last_grant resets to 1 so channel 0 takes the first tie.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r   <= T_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= 7'd0;
        end else begin
            tx_state_r   <= tx_state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    assign sel_rx_ready_s = ch_r ? rx1_ready : rx0_ready;
    assign rcnt_zero_s    = (rcnt_r == 7'd0);
    assign rx0_data       = rd_data;
    assign rx1_data       = rd_data;
    assign rx_busy        = (rx_state_r == R_PAY);

    // Pop strobe and receive-side qualifiers. rd_en is also held low during
    // reset because in header phase it would otherwise follow rd_empty.
    always_comb begin
        rd_en     = 1'b0;
        rx0_valid = 1'b0;
        rx1_valid = 1'b0;
        rx0_last  = 1'b0;
        rx1_last  = 1'b0;
        case (rx_state_r)
            R_HDR: begin
                rd_en = ~rd_empty & rst_n;
            end
            R_PAY: begin
                rd_en = ~rd_empty & sel_rx_ready_s & rst_n;
                if (ch_r) begin
                    rx1_valid = ~rd_empty;
                    rx1_last  = rcnt_zero_s;
                end else begin
                    rx0_valid = ~rd_empty;
                    rx0_last  = rcnt_zero_s;
                end
            end
            default: begin
                rd_en = 1'b0;
            end
        endcase
    end

    // RX next-state logic: decode a header, then count payload pops.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        ch_nxt_s       = ch_r;
        rcnt_nxt_s     = rcnt_r;
        case (rx_state_r)
            R_HDR: begin
                if (rd_en) begin
                    ch_nxt_s       = rd_data[7];
                    rcnt_nxt_s     = rd_data[6:0];
                    rx_state_nxt_s = R_PAY;
                end else begin
                    rx_state_nxt_s = R_HDR;
                end
            end
            R_PAY: begin
                if (rd_en) begin
                    if (rcnt_zero_s) begin
                        rx_state_nxt_s = R_HDR;
                    end else begin
                        rcnt_nxt_s = rcnt_r - 7'd1;
                    end
                end else begin
                    rx_state_nxt_s = R_PAY;
                end
            end
            default: begin
                rx_state_nxt_s = R_HDR;
            end
        endcase
    end

    // RX registers.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= R_HDR;
            ch_r       <= 1'b0;
            rcnt_r     <= 7'd0;
        end else begin
            rx_state_r <= rx_state_nxt_s;
            ch_r       <= ch_nxt_s;
            rcnt_r     <= rcnt_nxt_s;
        end
    end

    ft245_channel_mux_checker u_checker (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_full   (wr_full),
        .rd_en     (rd_en),
        .rd_empty  (rd_empty),
        .tx0_done  (tx0_done),
        .tx1_done  (tx1_done),
        .rx0_valid (rx0_valid),
        .rx1_valid (rx1_valid)
    );

endmodule
